// File: rtl/new_means_seq_divider_if.sv
// Operand, handshake and result bundle between the k-means controller and the
// new-means divider.
interface new_means_seq_divider_if #(
    parameter int CENT_NUM = 8,
    parameter int DIM      = 7,
    parameter int ACC_W    = 22,
    parameter int CORD_W   = 13,
    parameter int CNT_W    = 10,
    parameter int IDX_W    = $clog2(CENT_NUM)
);
    logic                           start;
    logic [CENT_NUM*DIM*ACC_W-1:0]  accum_all;
    logic [CENT_NUM*CNT_W-1:0]      cnt_all;
    logic [CENT_NUM*DIM*CORD_W-1:0] old_cent_all;
    logic [CORD_W-1:0]              thresh;
    logic                           busy;
    logic                           cent_wr_en;
    logic [IDX_W-1:0]               cent_wr_idx;
    logic [DIM*CORD_W-1:0]          cent_wr_data;
    logic                           done;
    logic                           converged;
    logic [CENT_NUM-1:0]            empty_mask;
    logic                           divide_by_0;

    modport slave (
        input  start, accum_all, cnt_all, old_cent_all, thresh,
        output busy, cent_wr_en, cent_wr_idx, cent_wr_data, done,
               converged, empty_mask, divide_by_0
    );

    modport master (
        output start, accum_all, cnt_all, old_cent_all, thresh,
        input  busy, cent_wr_en, cent_wr_idx, cent_wr_data, done,
               converged, empty_mask, divide_by_0
    );
endinterface

// File: rtl/new_means_seq_divider.sv
// Sequential new-means block: divides each centroid's coordinate sums by its
// point count on one shared restoring divider and writes the new centroids.
module new_means_seq_divider #(
    parameter int CENT_NUM = 8,
    parameter int DIM      = 7,
    parameter int ACC_W    = 22,
    parameter int CORD_W   = 13,
    parameter int CNT_W    = 10,
    parameter int IDX_W    = $clog2(CENT_NUM)
) (
    input logic                    clk,
    input logic                    rst_n,
    new_means_seq_divider_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_LOAD, S_DIV, S_FIX, S_WRITE, S_DONE
    } state_t;

    localparam int STEP_W = $clog2(ACC_W + 1);
    localparam int DIM_W  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [ACC_W-1:0] POS_LIM = ACC_W'((64'd1 << (CORD_W - 1)) - 64'd1);
    localparam logic [ACC_W-1:0] NEG_LIM = ACC_W'(64'd1 << (CORD_W - 1));

    state_t                     state_q;
    logic [IDX_W-1:0]           c_q;
    logic [DIM_W-1:0]           d_q;
    logic [STEP_W-1:0]          step_q;
    logic [ACC_W-1:0]           dvd_q;
    logic [CNT_W-1:0]           rem_q;
    logic [CNT_W-1:0]           dvs_q;
    logic                       neg_q;
    logic [DIM-1:0][CORD_W-1:0] buf_q;
    logic                       conv_acc_q;
    logic [CENT_NUM-1:0]        empty_acc_q;
    logic                       busy_q;
    logic                       wr_en_q;
    logic                       done_q;
    logic                       conv_q;
    logic [CENT_NUM-1:0]        empty_q;
    logic                       div0_q;

    logic [ACC_W-1:0]           acc_sel;
    logic [CNT_W-1:0]           cnt_sel;
    logic [DIM-1:0][CORD_W-1:0] old_cent;
    logic [CORD_W-1:0]          old_sel;

    always_comb begin
        cnt_sel  = bus.cnt_all[int'(c_q)*CNT_W +: CNT_W];
        acc_sel  = bus.accum_all[(int'(c_q)*DIM + int'(d_q))*ACC_W +: ACC_W];
        old_cent = bus.old_cent_all[int'(c_q)*DIM*CORD_W +: DIM*CORD_W];
        old_sel  = old_cent[d_q];
    end

    // One restoring step: remainder stays below the divisor, so CNT_W+1 bits
    // cover the shifted-in partial remainder.
    logic [CNT_W:0]   shifted;
    logic [CNT_W:0]   diff;
    logic             q_bit;
    logic [CNT_W-1:0] rem_nxt;

    always_comb begin
        shifted = {rem_q, dvd_q[ACC_W-1]};
        diff    = shifted - {1'b0, dvs_q};
        q_bit   = (shifted >= {1'b0, dvs_q});
        rem_nxt = q_bit ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
    end

    logic [CORD_W-1:0] fix_val;
    logic [CORD_W:0]   delta;
    logic [CORD_W:0]   dev;

    always_comb begin
        fix_val = dvd_q[CORD_W-1:0];
        if (neg_q) begin
            if (dvd_q > NEG_LIM) fix_val = {1'b1, {(CORD_W-1){1'b0}}};
            else                 fix_val = ~dvd_q[CORD_W-1:0] + CORD_W'(1);
        end else if (dvd_q > POS_LIM) begin
            fix_val = {1'b0, {(CORD_W-1){1'b1}}};
        end
        // One extra bit keeps new-old from wrapping at opposite extremes.
        delta = {fix_val[CORD_W-1], fix_val} - {old_sel[CORD_W-1], old_sel};
        dev   = delta[CORD_W] ? (~delta + (CORD_W+1)'(1)) : delta;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            c_q         <= '0;
            d_q         <= '0;
            step_q      <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            neg_q       <= 1'b0;
            buf_q       <= '0;
            conv_acc_q  <= 1'b0;
            empty_acc_q <= '0;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            conv_q      <= 1'b0;
            empty_q     <= '0;
            div0_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: if (bus.start) begin
                    c_q         <= '0;
                    d_q         <= '0;
                    conv_acc_q  <= 1'b1;
                    empty_acc_q <= '0;
                    busy_q      <= 1'b1;
                    state_q     <= S_CHECK;
                end
                S_CHECK: begin
                    if (cnt_sel == '0) begin
                        // Empty cluster keeps its old centroid and skips the divider.
                        empty_acc_q[c_q] <= 1'b1;
                        buf_q            <= old_cent;
                        wr_en_q          <= 1'b1;
                        state_q          <= S_WRITE;
                    end else begin
                        d_q     <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    rem_q   <= '0;
                    dvd_q   <= acc_sel[ACC_W-1] ? (~acc_sel + ACC_W'(1)) : acc_sel;
                    neg_q   <= acc_sel[ACC_W-1];
                    dvs_q   <= cnt_sel;
                    step_q  <= '0;
                    state_q <= S_DIV;
                end
                S_DIV: begin
                    dvd_q  <= {dvd_q[ACC_W-2:0], q_bit};
                    rem_q  <= rem_nxt;
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == STEP_W'(ACC_W - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    buf_q[d_q] <= fix_val;
                    if (dev > {1'b0, bus.thresh}) conv_acc_q <= 1'b0;
                    if (d_q == DIM_W'(DIM - 1)) begin
                        wr_en_q <= 1'b1;
                        state_q <= S_WRITE;
                    end else begin
                        d_q     <= d_q + DIM_W'(1);
                        state_q <= S_LOAD;
                    end
                end
                S_WRITE: begin
                    if (c_q == IDX_W'(CENT_NUM - 1)) begin
                        done_q  <= 1'b1;
                        conv_q  <= conv_acc_q;
                        empty_q <= empty_acc_q;
                        div0_q  <= |empty_acc_q;
                        state_q <= S_DONE;
                    end else begin
                        c_q     <= c_q + IDX_W'(1);
                        state_q <= S_CHECK;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.cent_wr_en   = wr_en_q;
    assign bus.cent_wr_idx  = c_q;
    assign bus.cent_wr_data = buf_q;
    assign bus.done         = done_q;
    assign bus.converged    = conv_q;
    assign bus.empty_mask   = empty_q;
    assign bus.divide_by_0  = div0_q;
endmodule

// File: tb/tb_new_means_seq_divider.sv
// Directed bench for new_means_seq_divider: reset, truncation, empty clusters,
// saturation, convergence threshold and start-while-busy behaviour.
module tb_new_means_seq_divider;
  localparam int CENT_NUM = 8, DIM = 7, ACC_W = 22, CORD_W = 13, CNT_W = 10, IDX_W = 3;
  localparam int FULL = 1361, EMPTY = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0;
  int cyc_g = 0, wr_n = 0;
  int wr_idx_log [16];
  int wr_cyc_log [16];
  logic [DIM*CORD_W-1:0] wr_dat_log [16];

  new_means_seq_divider_if #(.CENT_NUM(CENT_NUM), .DIM(DIM), .ACC_W(ACC_W),
    .CORD_W(CORD_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

  new_means_seq_divider #(.CENT_NUM(CENT_NUM), .DIM(DIM), .ACC_W(ACC_W),
    .CORD_W(CORD_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  always @(negedge clk) begin
    if (rst_n && bus.cent_wr_en === 1'b1) begin
      if (wr_n < 16) begin
        wr_idx_log[wr_n] = int'(bus.cent_wr_idx);
        wr_dat_log[wr_n] = bus.cent_wr_data;
        wr_cyc_log[wr_n] = cyc_g;
      end
      wr_n++;
    end
  end

  task automatic set_acc(input int c, input int d, input int v);
    bus.accum_all[(c*DIM+d)*ACC_W +: ACC_W] = ACC_W'(v);
  endtask
  task automatic set_cnt(input int c, input int v);
    bus.cnt_all[c*CNT_W +: CNT_W] = CNT_W'(v);
  endtask
  task automatic set_old(input int c, input int d, input int v);
    bus.old_cent_all[(c*DIM+d)*CORD_W +: CORD_W] = CORD_W'(v);
  endtask

  task automatic clear_inputs();
    bus.accum_all = '0; bus.cnt_all = '0; bus.old_cent_all = '0; bus.thresh = '0;
  endtask

  // Centroid 2 and 3 carry data; the rest have count 1 and zero sums.
  task automatic load_cfg_a();
    clear_inputs();
    for (int c = 0; c < CENT_NUM; c++) set_cnt(c, 1);
    set_acc(2, 0, 1693);  set_cnt(2, 13);
    set_acc(3, 0, -1528); set_acc(3, 2, -907); set_cnt(3, 11);
  endtask

  // Starts a pass, optionally re-pulses start at cycles p1/p2, returns cycles to done.
  task automatic run_pass(input int p1, input int p2, output int cyc);
    wr_n = 0;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; cyc = 1;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      bus.start = (cyc == p1 || cyc == p2);
    end
    bus.start = 1'b0;
    total++;
    if (bus.done !== 1'b1) begin bad++; $display("FAIL pass_timeout got=%0d cycles without done", cyc); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [DIM*CORD_W+CENT_NUM+IDX_W+5-1:0] v;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    v = {bus.busy, bus.cent_wr_en, bus.done, bus.converged, bus.divide_by_0,
         bus.empty_mask, bus.cent_wr_idx, bus.cent_wr_data};
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_outputs got=%0h want=0", v); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_div();
    logic [DIM*CORD_W+CENT_NUM+IDX_W+5-1:0] v;
    logic [DIM-1:0][CORD_W-1:0] e2;
    int cyc;
    load_cfg_a();
    wr_n = 0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL middiv_busy got=%0b want=1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    v = {bus.busy, bus.cent_wr_en, bus.done, bus.converged, bus.divide_by_0,
         bus.empty_mask, bus.cent_wr_idx, bus.cent_wr_data};
    total++;
    if (v !== '0) begin bad++; $display("FAIL middiv_reset_outputs got=%0h want=0", v); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || wr_n !== 0) begin
      bad++; $display("FAIL middiv_idle got busy=%0b writes=%0d want busy=0 writes=0", bus.busy, wr_n);
    end
    run_pass(0, 0, cyc);
    e2 = '0; e2[0] = CORD_W'(130);
    total++;
    if (cyc !== FULL) begin bad++; $display("FAIL middiv_rerun_len got=%0d want=%0d", cyc, FULL); end
    total++;
    if (wr_n !== 8 || wr_dat_log[2] !== e2) begin
      bad++; $display("FAIL middiv_rerun_data got writes=%0d c2=%0h want 8 %0h", wr_n, wr_dat_log[2], e2);
    end
  endtask

  task automatic test_truncation();
    logic [DIM-1:0][CORD_W-1:0] e;
    int cyc;
    load_cfg_a();
    run_pass(0, 0, cyc);
    total++;
    if (cyc !== FULL) begin bad++; $display("FAIL trunc_len got=%0d want=%0d", cyc, FULL); end
    total++;
    if (wr_n !== 8) begin bad++; $display("FAIL trunc_writes got=%0d want=8", wr_n); end
    for (int i = 0; i < CENT_NUM; i++) begin
      e = '0;
      if (i == 2) e[0] = CORD_W'(130);
      if (i == 3) begin e[0] = CORD_W'(-138); e[2] = CORD_W'(-82); end
      total++;
      if (wr_idx_log[i] !== i || wr_dat_log[i] !== e) begin
        bad++; $display("FAIL trunc_cent%0d got idx=%0d data=%0h want idx=%0d data=%0h",
                        i, wr_idx_log[i], wr_dat_log[i], i, e);
      end
    end
    total++;
    if ({bus.converged, bus.divide_by_0, bus.empty_mask, bus.done} !== '0) begin
      bad++; $display("FAIL trunc_flags got conv=%0b div0=%0b mask=%0h done=%0b want all 0",
                      bus.converged, bus.divide_by_0, bus.empty_mask, bus.done);
    end
  endtask

  task automatic test_all_empty();
    logic [DIM-1:0][CORD_W-1:0] e;
    int cyc;
    clear_inputs();
    for (int c = 0; c < CENT_NUM; c++)
      for (int d = 0; d < DIM; d++) set_old(c, d, (c*DIM+d)*37 - 900);
    run_pass(0, 0, cyc);
    total++;
    if (cyc !== EMPTY) begin bad++; $display("FAIL empty_len got=%0d want=%0d", cyc, EMPTY); end
    total++;
    if (wr_n !== 8) begin bad++; $display("FAIL empty_writes got=%0d want=8", wr_n); end
    for (int i = 0; i < CENT_NUM; i++) begin
      for (int d = 0; d < DIM; d++) e[d] = CORD_W'((i*DIM+d)*37 - 900);
      total++;
      if (wr_idx_log[i] !== i || wr_dat_log[i] !== e) begin
        bad++; $display("FAIL empty_cent%0d got idx=%0d data=%0h want idx=%0d data=%0h",
                        i, wr_idx_log[i], wr_dat_log[i], i, e);
      end
      if (i > 0) begin
        total++;
        if (wr_cyc_log[i] - wr_cyc_log[i-1] !== 2) begin
          bad++; $display("FAIL empty_spacing%0d got=%0d want=2", i, wr_cyc_log[i] - wr_cyc_log[i-1]);
        end
      end
    end
    total++;
    if (bus.empty_mask !== 8'hFF || bus.divide_by_0 !== 1'b1 || bus.converged !== 1'b1) begin
      bad++; $display("FAIL empty_flags got mask=%0h div0=%0b conv=%0b want ff 1 1",
                      bus.empty_mask, bus.divide_by_0, bus.converged);
    end
  endtask

  task automatic test_saturate();
    logic [DIM-1:0][CORD_W-1:0] e;
    int cyc;
    clear_inputs();
    for (int c = 0; c < CENT_NUM; c++) begin
      set_cnt(c, 1);
      for (int d = 0; d < DIM; d++) set_acc(c, d, (d % 2 == 0) ? 5000 : -5000);
    end
    set_acc(7, 6, -2097152);
    run_pass(0, 0, cyc);
    total++;
    if (cyc !== FULL) begin bad++; $display("FAIL sat_len got=%0d want=%0d", cyc, FULL); end
    for (int i = 0; i < CENT_NUM; i++) begin
      for (int d = 0; d < DIM; d++) e[d] = (d % 2 == 0) ? 13'h0FFF : 13'h1000;
      if (i == 7) e[6] = 13'h1000;
      total++;
      if (wr_dat_log[i] !== e) begin
        bad++; $display("FAIL sat_cent%0d got=%0h want=%0h", i, wr_dat_log[i], e);
      end
    end
    total++;
    if (bus.empty_mask !== '0 || bus.converged !== 1'b0) begin
      bad++; $display("FAIL sat_flags got mask=%0h conv=%0b want 0 0", bus.empty_mask, bus.converged);
    end
  endtask

  task automatic test_converge();
    int cyc;
    load_cfg_a();
    set_old(2, 0, 130); set_old(3, 0, -138); set_old(3, 2, -79);
    bus.thresh = CORD_W'(3);
    run_pass(0, 0, cyc);
    total++;
    if (bus.converged !== 1'b1) begin bad++; $display("FAIL conv_thresh3 got=%0b want=1", bus.converged); end
    bus.thresh = CORD_W'(2);
    run_pass(0, 0, cyc);
    total++;
    if (bus.converged !== 1'b0) begin bad++; $display("FAIL conv_thresh2 got=%0b want=0", bus.converged); end
  endtask

  task automatic test_start_busy();
    int cyc;
    load_cfg_a();
    run_pass(50, 700, cyc);
    total++;
    if (cyc !== FULL) begin bad++; $display("FAIL busy_len got=%0d want=%0d", cyc, FULL); end
    total++;
    if (wr_n !== 8) begin bad++; $display("FAIL busy_writes got=%0d want=8", wr_n); end
    for (int i = 0; i < CENT_NUM; i++) begin
      total++;
      if (wr_idx_log[i] !== i) begin bad++; $display("FAIL busy_idx%0d got=%0d want=%0d", i, wr_idx_log[i], i); end
    end
    // start held high: exactly one IDLE cycle after DONE before the next pass.
    clear_inputs();
    @(negedge clk); bus.start = 1'b1; cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    total++;
    if (cyc !== EMPTY) begin bad++; $display("FAIL held_len got=%0d want=%0d", cyc, EMPTY); end
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL held_idle got busy=%0b want=0", bus.busy); end
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL held_restart got busy=%0b want=1", bus.busy); end
    bus.start = 1'b0; cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    total++;
    if (bus.done !== 1'b1) begin bad++; $display("FAIL held_second_done got=%0b want=1", bus.done); end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.start = 1'b0;
    clear_inputs();
    test_reset();
    test_reset_mid_div();
    test_truncation();
    test_all_empty();
    test_saturate();
    test_converge();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
